// File: rtl/axi_shim_ot.sv
// axi_shim_ot: turns cache/PTW read and write requests into AXI4 AR/AW/W transactions
// and passes R/B responses straight back, limiting outstanding transactions per direction.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   rd_req_i .. rd_id_i    read request (held until rd_gnt_o), rd_gnt_o on AR handshake
//   rd_rdy_i, rd_*_o       R channel pass-through (rd_rdy_i drives r_ready)
//   wr_req_i .. wr_id_i    write request with all beats presented at once (held until wr_gnt_o)
//   wr_rdy_i, wr_*_o       B channel pass-through (wr_rdy_i drives b_ready)
//   axi_req_o, axi_resp_i  AXI4+ATOP master port
package axi_shim_ot_pkg;
    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  atop;
    } aw_chan_t;
    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
    } ar_chan_t;
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } w_chan_t;
    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_chan_t;
    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;
    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;
    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;
endpackage

module axi_shim_ot #(
    parameter int unsigned AxiAddrWidth   = 64,
    parameter int unsigned AxiDataWidth   = 64,
    parameter int unsigned AxiIdWidth     = 4,
    parameter int unsigned AxiNumWords    = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter type axi_req_t  = axi_shim_ot_pkg::req_t,
    parameter type axi_resp_t = axi_shim_ot_pkg::resp_t,
    localparam int unsigned BlenW = (AxiNumWords > 1) ? $clog2(AxiNumWords) : 1
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic                                         rd_req_i,
    output logic                                         rd_gnt_o,
    input  logic [AxiAddrWidth-1:0]                      rd_addr_i,
    input  logic [BlenW-1:0]                             rd_blen_i,
    input  logic [2:0]                                   rd_size_i,
    input  logic [AxiIdWidth-1:0]                        rd_id_i,
    input  logic                                         rd_rdy_i,
    output logic                                         rd_valid_o,
    output logic                                         rd_last_o,
    output logic [AxiDataWidth-1:0]                      rd_data_o,
    output logic [AxiIdWidth-1:0]                        rd_id_o,
    output logic [1:0]                                   rd_resp_o,
    input  logic                                         wr_req_i,
    output logic                                         wr_gnt_o,
    input  logic [AxiAddrWidth-1:0]                      wr_addr_i,
    input  logic [AxiNumWords-1:0][AxiDataWidth-1:0]     wr_data_i,
    input  logic [AxiNumWords-1:0][AxiDataWidth/8-1:0]   wr_be_i,
    input  logic [BlenW-1:0]                             wr_blen_i,
    input  logic [2:0]                                   wr_size_i,
    input  logic [AxiIdWidth-1:0]                        wr_id_i,
    input  logic                                         wr_rdy_i,
    output logic                                         wr_valid_o,
    output logic [AxiIdWidth-1:0]                        wr_id_o,
    output logic [1:0]                                   wr_resp_o,
    output axi_req_t                                     axi_req_o,
    input  axi_resp_t                                    axi_resp_i
);
    localparam int unsigned OtW = $clog2(MaxOutstanding + 1);

    typedef enum logic {IDLE, SEND} state_e;

    state_e           state_q, state_d;
    logic             aw_done_q, aw_done_d;
    logic             w_done_q, w_done_d;
    logic [BlenW-1:0] beat_q, beat_d;
    logic [OtW-1:0]   rd_ot_q, wr_ot_q;

    logic rd_ok, wr_ok, ar_valid, r_last_hs, b_hs;
    logic wr_act, aw_valid, w_valid, w_last, aw_fin, w_fin;

    assign rd_ok     = rd_ot_q < OtW'(MaxOutstanding);
    assign wr_ok     = wr_ot_q < OtW'(MaxOutstanding);
    assign ar_valid  = rd_req_i & rd_ok;
    assign rd_gnt_o  = ar_valid & axi_resp_i.ar_ready;
    assign r_last_hs = axi_resp_i.r_valid & rd_rdy_i & axi_resp_i.r.last;
    assign b_hs      = axi_resp_i.b_valid & wr_rdy_i;

    assign rd_valid_o = axi_resp_i.r_valid;
    assign rd_last_o  = axi_resp_i.r.last;
    assign rd_data_o  = axi_resp_i.r.data;
    assign rd_id_o    = axi_resp_i.r.id;
    assign rd_resp_o  = axi_resp_i.r.resp;
    assign wr_valid_o = axi_resp_i.b_valid;
    assign wr_id_o    = axi_resp_i.b.id;
    assign wr_resp_o  = axi_resp_i.b.resp;

    // A write is active while in SEND, or in IDLE when a request is present and
    // the outstanding limit allows it. AW and the W burst finish independently;
    // the grant fires once both are done, whichever completes last.
    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        beat_d    = beat_q;
        wr_gnt_o  = 1'b0;
        wr_act    = (state_q == SEND) | (wr_req_i & wr_ok);
        aw_valid  = wr_act & ~aw_done_q;
        w_valid   = wr_act & ~w_done_q;
        w_last    = beat_q == wr_blen_i;
        aw_fin    = aw_done_q | (aw_valid & axi_resp_i.aw_ready);
        w_fin     = w_done_q | (w_valid & axi_resp_i.w_ready & w_last);
        if (wr_act && aw_fin && w_fin) begin
            wr_gnt_o  = 1'b1;
            state_d   = IDLE;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            beat_d    = '0;
        end else if (wr_act) begin
            state_d   = SEND;
            aw_done_d = aw_fin;
            w_done_d  = w_fin;
            beat_d    = (w_valid && axi_resp_i.w_ready && !w_last) ? beat_q + BlenW'(1) : beat_q;
        end
    end

    always_comb begin
        axi_req_o           = '0;
        axi_req_o.ar.id     = rd_id_i;
        axi_req_o.ar.addr   = rd_addr_i;
        axi_req_o.ar.len    = 8'(rd_blen_i);
        axi_req_o.ar.size   = rd_size_i;
        axi_req_o.ar.burst  = 2'b01;
        axi_req_o.ar_valid  = ar_valid;
        axi_req_o.aw.id     = wr_id_i;
        axi_req_o.aw.addr   = wr_addr_i;
        axi_req_o.aw.len    = 8'(wr_blen_i);
        axi_req_o.aw.size   = wr_size_i;
        axi_req_o.aw.burst  = 2'b01;
        axi_req_o.aw_valid  = aw_valid;
        axi_req_o.w.data    = wr_data_i[beat_q];
        axi_req_o.w.strb    = wr_be_i[beat_q];
        axi_req_o.w.last    = w_last;
        axi_req_o.w_valid   = w_valid;
        axi_req_o.r_ready   = rd_rdy_i;
        axi_req_o.b_ready   = wr_rdy_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            beat_q    <= beat_d;
        end
    end

    // A response arriving with nothing outstanding is ignored so the counter
    // holds at zero instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ot_q <= '0;
            wr_ot_q <= '0;
        end else begin
            rd_ot_q <= rd_ot_q + OtW'(rd_gnt_o) - OtW'(r_last_hs && rd_ot_q != '0);
            wr_ot_q <= wr_ot_q + OtW'(wr_gnt_o) - OtW'(b_hs && wr_ot_q != '0);
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) !(r_last_hs && rd_ot_q == '0));
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(b_hs && wr_ot_q == '0));
endmodule

// File: tb/tb_axi_shim_ot.sv
// tb_axi_shim_ot: self-checking bench for axi_shim_ot (vector table, directed corner cases, random vs model)
module tb_axi_shim_ot;
    import axi_shim_ot_pkg::*;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic             rd_req, rd_gnt, rd_rdy, rd_valid, rd_last;
    logic [63:0]      rd_addr, rd_data;
    logic [1:0]       rd_blen, rd_resp;
    logic [2:0]       rd_size;
    logic [3:0]       rd_id, rd_id_o;
    logic             wr_req, wr_gnt, wr_rdy, wr_valid;
    logic [63:0]      wr_addr;
    logic [3:0][63:0] wr_data;
    logic [3:0][7:0]  wr_be;
    logic [1:0]       wr_blen, wr_resp;
    logic [2:0]       wr_size;
    logic [3:0]       wr_id, wr_id_o;
    req_t             axi_req, axi_req4;
    resp_t            axi_resp;

    logic             rd_gnt4, rd_valid4, rd_last4, wr_gnt4, wr_valid4, wr_rdy4;
    logic [63:0]      rd_data4;
    logic [3:0]       rd_id4, wr_id4;
    logic [1:0]       rd_resp4, wr_resp4;

    axi_shim_ot #(.MaxOutstanding(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rd_req_i(rd_req), .rd_gnt_o(rd_gnt), .rd_addr_i(rd_addr), .rd_blen_i(rd_blen),
        .rd_size_i(rd_size), .rd_id_i(rd_id), .rd_rdy_i(rd_rdy), .rd_valid_o(rd_valid),
        .rd_last_o(rd_last), .rd_data_o(rd_data), .rd_id_o(rd_id_o), .rd_resp_o(rd_resp),
        .wr_req_i(wr_req), .wr_gnt_o(wr_gnt), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_be_i(wr_be), .wr_blen_i(wr_blen), .wr_size_i(wr_size), .wr_id_i(wr_id),
        .wr_rdy_i(wr_rdy), .wr_valid_o(wr_valid), .wr_id_o(wr_id_o), .wr_resp_o(wr_resp),
        .axi_req_o(axi_req), .axi_resp_i(axi_resp)
    );

    // Deeper instance for the counter-simultaneity case; its response readies are
    // separate so it never sees responses for transactions it did not issue.
    axi_shim_ot #(.MaxOutstanding(4)) u_dut4 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rd_req_i(rd_req), .rd_gnt_o(rd_gnt4), .rd_addr_i(rd_addr), .rd_blen_i(rd_blen),
        .rd_size_i(rd_size), .rd_id_i(rd_id), .rd_rdy_i(1'b0), .rd_valid_o(rd_valid4),
        .rd_last_o(rd_last4), .rd_data_o(rd_data4), .rd_id_o(rd_id4), .rd_resp_o(rd_resp4),
        .wr_req_i(wr_req), .wr_gnt_o(wr_gnt4), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_be_i(wr_be), .wr_blen_i(wr_blen), .wr_size_i(wr_size), .wr_id_i(wr_id),
        .wr_rdy_i(wr_rdy4), .wr_valid_o(wr_valid4), .wr_id_o(wr_id4), .wr_resp_o(wr_resp4),
        .axi_req_o(axi_req4), .axi_resp_i(axi_resp)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rd_req = 0; rd_addr = '0; rd_blen = '0; rd_size = '0; rd_id = '0; rd_rdy = 0;
        wr_req = 0; wr_addr = '0; wr_blen = '0; wr_size = '0; wr_id = '0; wr_rdy = 0; wr_rdy4 = 0;
        for (int k = 0; k < 4; k++) begin
            wr_data[k] = 64'hC0DE_0000_0000_0000 | 64'(k);
            wr_be[k] = 8'h0F << k;
        end
        axi_resp = '0;
    endtask

    task automatic do_reset();
        rst_ni = 0;
        idle_inputs();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1;
    endtask

    // in  = {wr_req, wr_blen[1:0], aw_ready, w_ready, rd_req, ar_ready, rd_rdy, wr_rdy}
    // out = {aw_valid, w_valid, wr_gnt, w_last, ar_valid, rd_gnt, r_ready, b_ready}
    typedef struct {
        string      nm;
        logic [8:0] in;
        logic [7:0] out;
    } vec_t;

    vec_t vecs[9];

    int  rd_out, wr_out, beats;
    bit  wr_busy, aw_sent, e_arv, e_rg, act, e_awv, e_wv, aw_now, e_wg;
    int  bn;

    initial begin
        vecs[0] = '{"v_idle",      9'b0_00_00_0000, 8'b0001_0000};
        vecs[1] = '{"v_wr1_rdy",   9'b1_00_11_0000, 8'b1111_0000};
        vecs[2] = '{"v_wr1_awlo",  9'b1_00_01_0000, 8'b1101_0000};
        vecs[3] = '{"v_wr4_rdy",   9'b1_11_11_0000, 8'b1100_0000};
        vecs[4] = '{"v_wr4_stall", 9'b1_11_00_0000, 8'b1100_0000};
        vecs[5] = '{"v_rd_rdy",    9'b0_00_00_1100, 8'b0001_1100};
        vecs[6] = '{"v_rd_stall",  9'b0_00_00_1000, 8'b0001_1000};
        vecs[7] = '{"v_resp_rdy",  9'b0_01_00_0011, 8'b0000_0011};
        vecs[8] = '{"v_both",      9'b1_01_11_1110, 8'b1100_1110};

        for (int i = 0; i < 9; i++) begin
            do_reset();
            {wr_req, wr_blen, axi_resp.aw_ready, axi_resp.w_ready, rd_req, axi_resp.ar_ready, rd_rdy, wr_rdy} = vecs[i].in;
            @(negedge clk_i);
            check(vecs[i].nm, {axi_req.aw_valid, axi_req.w_valid, wr_gnt, axi_req.w.last,
                               axi_req.ar_valid, rd_gnt, axi_req.r_ready, axi_req.b_ready}, vecs[i].out);
            idle_inputs();
        end

        // single-beat write granted in the request cycle, counter 0 -> 1
        do_reset();
        wr_req = 1; wr_addr = 64'h8000_1000; wr_id = 4'h3;
        axi_resp.aw_ready = 1; axi_resp.w_ready = 1;
        @(negedge clk_i);
        check("a_gnt", wr_gnt, 1);
        check("a_last", axi_req.w.last, 1);
        check("a_data", axi_req.w.data, 64'hC0DE_0000_0000_0000);
        check("a_awaddr", axi_req.aw.addr, 64'h8000_1000);
        check("a_ot0", dut.wr_ot_q, 0);
        @(posedge clk_i); #1 wr_req = 0;
        check("a_ot1", dut.wr_ot_q, 1);

        // 4-beat write, AW stalled 6 cycles: W beats stream first, grant when AW lands
        do_reset();
        wr_req = 1; wr_blen = 3; axi_resp.w_ready = 1;
        for (int c = 0; c < 7; c++) begin
            axi_resp.aw_ready = (c == 6);
            @(negedge clk_i);
            check("b_awv", axi_req.aw_valid, 1);
            check("b_wv", axi_req.w_valid, c < 4);
            if (c < 4) begin
                check("b_data", axi_req.w.data, 64'hC0DE_0000_0000_0000 | 64'(c));
                check("b_last", axi_req.w.last, c == 3);
            end
            check("b_gnt", wr_gnt, c == 6);
            @(posedge clk_i); #1;
        end
        wr_req = 0; axi_resp.aw_ready = 0;
        @(negedge clk_i);
        check("b_idle", {axi_req.aw_valid, axi_req.w_valid, wr_gnt}, 0);

        // 4-beat write, w_ready toggling, AW accepted in cycle 2
        do_reset();
        wr_req = 1; wr_blen = 3;
        begin
            int k;
            k = 0;
            for (int c = 0; c < 7; c++) begin
                axi_resp.w_ready = (c % 2 == 0);
                axi_resp.aw_ready = (c == 2);
                @(negedge clk_i);
                check("c_wv", axi_req.w_valid, 1);
                check("c_data", axi_req.w.data, 64'hC0DE_0000_0000_0000 | 64'(k));
                check("c_strb", axi_req.w.strb, 8'h0F << k);
                check("c_last", axi_req.w.last, k == 3);
                check("c_awv", axi_req.aw_valid, c <= 2);
                check("c_gnt", wr_gnt, c == 6);
                if (axi_resp.w_ready) k++;
                @(posedge clk_i); #1;
            end
        end
        wr_req = 0; axi_resp = '0;

        // read limiting with MaxOutstanding = 2
        do_reset();
        rd_req = 1; rd_id = 1; rd_addr = 64'h100; axi_resp.ar_ready = 1;
        @(negedge clk_i); check("d_gnt1", rd_gnt, 1);
        check("d_araddr", axi_req.ar.addr, 64'h100);
        @(posedge clk_i); #1 rd_id = 2;
        @(negedge clk_i); check("d_gnt2", rd_gnt, 1);
        @(posedge clk_i); #1 rd_id = 3;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            check("d_arv_blk", axi_req.ar_valid, 0);
            check("d_gnt_blk", rd_gnt, 0);
            @(posedge clk_i); #1;
        end
        axi_resp.r_valid = 1; axi_resp.r.last = 1; axi_resp.r.id = 0;
        axi_resp.r.data = 64'hFEED_BEEF; axi_resp.r.resp = 2'b10; rd_rdy = 1;
        @(negedge clk_i);
        check("d_rvalid", rd_valid, 1);
        check("d_rid", rd_id_o, 0);
        check("d_rlast", rd_last, 1);
        check("d_rdata", rd_data, 64'hFEED_BEEF);
        check("d_rresp", rd_resp, 2'b10);
        check("d_arv_same", axi_req.ar_valid, 0);
        @(posedge clk_i); #1 axi_resp.r_valid = 0; axi_resp.r.last = 0;
        @(negedge clk_i);
        check("d_arv_next", axi_req.ar_valid, 1);
        check("d_gnt3", rd_gnt, 1);
        @(posedge clk_i); #1 rd_req = 0;
        check("d_ot", dut.rd_ot_q, 2);

        // B handshake and a new grant in the same cycle at wr_ot_q = 2
        do_reset();
        wr_req = 1; axi_resp.aw_ready = 1; axi_resp.w_ready = 1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        axi_resp.b_valid = 1; axi_resp.b.id = 4'h5; axi_resp.b.resp = 2'b01; wr_rdy4 = 1; wr_rdy = 1;
        @(negedge clk_i);
        check("e_ot_pre", u_dut4.wr_ot_q, 2);
        check("e_gnt", wr_gnt4, 1);
        check("e_bvalid", wr_valid4, 1);
        check("e_bid", wr_id4, 4'h5);
        check("e_bresp", wr_resp4, 2'b01);
        check("e_lim_awv", axi_req.aw_valid, 0);
        @(posedge clk_i); #1 idle_inputs();
        check("e_ot_post", u_dut4.wr_ot_q, 2);

        // reset asserted while beat 2 of a 4-beat write is presented
        do_reset();
        wr_req = 1; wr_blen = 3; axi_resp.w_ready = 1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        check("f_beat2", axi_req.w.data, 64'hC0DE_0000_0000_0000 | 64'd2);
        #2 rst_ni = 0; wr_req = 0;
        #1 check("f_rst_valid", {axi_req.aw_valid, axi_req.w_valid}, 0);
        check("f_rst_beat", dut.beat_q, 0);
        @(posedge clk_i); #1 rst_ni = 1;
        @(negedge clk_i);
        check("f_idle", {axi_req.aw_valid, axi_req.w_valid, wr_gnt}, 0);
        check("f_ot", dut.wr_ot_q, 0);
        @(posedge clk_i); #1 wr_req = 1; wr_blen = 0; axi_resp.aw_ready = 1;
        @(negedge clk_i);
        check("f_data0", axi_req.w.data, 64'hC0DE_0000_0000_0000);
        check("f_gnt", wr_gnt, 1);
        @(posedge clk_i); #1;

        // random traffic against a transaction-level model
        do_reset();
        rd_out = 0; wr_out = 0; beats = 0; wr_busy = 0; aw_sent = 0;
        for (int n = 0; n < 600; n++) begin
            if (!rd_req && $urandom_range(0, 1) == 1) begin
                rd_req = 1; rd_addr = {$urandom(), $urandom()}; rd_id = 4'($urandom());
                rd_blen = 2'($urandom()); rd_size = 3'($urandom());
            end
            if (!wr_req && $urandom_range(0, 1) == 1) begin
                wr_req = 1; wr_addr = {$urandom(), $urandom()}; wr_id = 4'($urandom());
                wr_blen = 2'($urandom()); wr_size = 3'($urandom());
                for (int k = 0; k < 4; k++) begin
                    wr_data[k] = {$urandom(), $urandom()};
                    wr_be[k] = 8'($urandom());
                end
            end
            axi_resp.ar_ready = 1'($urandom());
            axi_resp.aw_ready = 1'($urandom());
            axi_resp.w_ready = 1'($urandom());
            axi_resp.r_valid = 1'($urandom());
            axi_resp.r.last = (rd_out > 0) && ($urandom_range(0, 1) == 1);
            axi_resp.r.id = 4'($urandom());
            axi_resp.r.data = {$urandom(), $urandom()};
            axi_resp.r.resp = 2'($urandom());
            axi_resp.b_valid = (wr_out > 0) && ($urandom_range(0, 1) == 1);
            axi_resp.b.id = 4'($urandom());
            axi_resp.b.resp = 2'($urandom());
            rd_rdy = 1'($urandom());
            wr_rdy = 1'($urandom());
            @(negedge clk_i);
            e_arv  = rd_req && rd_out < 2;
            e_rg   = e_arv && axi_resp.ar_ready;
            act    = wr_busy || (wr_req && wr_out < 2);
            e_awv  = act && !aw_sent;
            e_wv   = act && beats <= int'(wr_blen);
            aw_now = aw_sent || (e_awv && axi_resp.aw_ready);
            bn     = beats + ((e_wv && axi_resp.w_ready) ? 1 : 0);
            e_wg   = act && aw_now && bn == int'(wr_blen) + 1;
            check("r_arv", axi_req.ar_valid, e_arv);
            check("r_rgnt", rd_gnt, e_rg);
            check("r_awv", axi_req.aw_valid, e_awv);
            check("r_wv", axi_req.w_valid, e_wv);
            check("r_wgnt", wr_gnt, e_wg);
            if (e_wv) begin
                check("r_wdata", axi_req.w.data, wr_data[beats]);
                check("r_wstrb", axi_req.w.strb, wr_be[beats]);
                check("r_wlast", axi_req.w.last, beats == int'(wr_blen));
            end
            if (e_awv) check("r_aw", {axi_req.aw.id, axi_req.aw.len, axi_req.aw.burst, axi_req.aw.size},
                             {wr_id, 6'd0, wr_blen, 2'b01, wr_size});
            if (e_arv) check("r_araddr", axi_req.ar.addr, rd_addr);
            check("r_rdata", rd_data, axi_resp.r.data);
            check("r_bpass", {wr_valid, wr_id_o, wr_resp}, {axi_resp.b_valid, axi_resp.b.id, axi_resp.b.resp});
            rd_out += (e_rg ? 1 : 0) - ((axi_resp.r_valid && rd_rdy && axi_resp.r.last) ? 1 : 0);
            if (e_wg) begin
                wr_busy = 0; aw_sent = 0; beats = 0; wr_out++;
            end else if (act) begin
                wr_busy = 1; aw_sent = aw_now; beats = bn;
            end
            if (axi_resp.b_valid && wr_rdy) wr_out--;
            @(posedge clk_i); #1;
            if (e_rg) rd_req = 0;
            if (e_wg) wr_req = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_shim_ot.md
# axi_shim_ot

Parametrised successor of the core-side AXI shim. It converts cache/PTW-style read and write requests into AXI4 AR/AW/W transactions and passes R/B responses back unbuffered. Compared with the fixed 64-bit shim it adds:
- configurable address, data and ID widths;
- fully decoupled AW and W handshakes;
- per-direction outstanding-transaction limiting, with counters that gate new requests.

It sits between the L1 caches and the SoC AXI crossbar.

## Interface
Parameters:
- AxiAddrWidth, 64, address width
- AxiDataWidth, 64, data/beat width; strobe width is AxiDataWidth/8
- AxiIdWidth, 4, transaction ID width
- AxiNumWords, 4, maximum burst length in beats, >=1; BlenW = max(1, clog2(AxiNumWords))
- MaxOutstanding, 4, maximum accepted-but-unanswered transactions per direction, >=1; counter width clog2(MaxOutstanding+1)
- axi_req_t, axi_resp_t, type parameters: AXI4+ATOP request/response structs matching the widths above

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- rd_req_i  in  1  read request; held with its fields until rd_gnt_o
- rd_gnt_o  out  1  AR handshake done
- rd_addr_i  in  AxiAddrWidth  read address
- rd_blen_i  in  BlenW  beats-1
- rd_size_i  in  3  AXI size
- rd_id_i  in  AxiIdWidth  read ID
- rd_rdy_i  in  1  consumer ready, driven onto r_ready
- rd_valid_o  out  1  R beat valid
- rd_last_o  out  1  R last
- rd_data_o  out  AxiDataWidth  R data
- rd_id_o  out  AxiIdWidth  R ID
- rd_resp_o  out  2  R resp
- wr_req_i  in  1  write request; held with all fields until wr_gnt_o
- wr_gnt_o  out  1  AW and all W beats handshaken
- wr_addr_i  in  AxiAddrWidth  write address
- wr_data_i  in  AxiNumWords x AxiDataWidth  beat data, beat k at index k
- wr_be_i  in  AxiNumWords x AxiDataWidth/8  beat strobes
- wr_blen_i  in  BlenW  beats-1
- wr_size_i  in  3  AXI size
- wr_id_i  in  AxiIdWidth  write ID
- wr_rdy_i  in  1  driven onto b_ready
- wr_valid_o  out  1  B valid
- wr_id_o  out  AxiIdWidth  B ID
- wr_resp_o  out  2  B resp
- axi_req_o  out  axi_req_t  AXI master request
- axi_resp_i  in  axi_resp_t  AXI master response

## Operation
AW/AR field settings:
- burst = INCR; len = zero-extended blen.
- prot, cache, qos, region, lock and atop are all 0. Exclusive and atomic accesses are out of scope.

Read path:
- ar_valid = rd_req_i & (rd_ot_q < MaxOutstanding).
- rd_gnt_o = ar_valid & ar_ready.
- rd_ot_q increments on rd_gnt_o and decrements on an R handshake with last. When both occur in the same cycle it is unchanged.

Write FSM has two states, IDLE and SEND, with flag aw_done_q and beat counter beat_q (BlenW bits).
- IDLE: if wr_req_i & (wr_ot_q < MaxOutstanding), assert aw_valid and w_valid in the same cycle.
- If the AW handshake and the final W beat both complete in that cycle, assert wr_gnt_o and stay in IDLE.
- Otherwise go to SEND, recording aw_done and beat progress.
- SEND: aw_valid = ~aw_done_q; w_valid = 1 until the final beat is handshaken.
- W beats may complete before AW. Once the final beat is handshaken, w_valid is held 0.
- wr_gnt_o pulses in the cycle the last outstanding item (AW or the final W) handshakes. Return to IDLE, clear aw_done_q and beat_q.
- w.data = wr_data_i[beat_q]; w.strb = wr_be_i[beat_q]; w.last = (beat_q == wr_blen_i); beat_q increments on each non-last W handshake.
- wr_ot_q increments on wr_gnt_o and decrements on a B handshake, with the same simultaneity rule as rd_ot_q.
- A B or R-last handshake when the counter is 0 triggers a simulation assertion, and the counter holds at 0.

Response path is pure pass-through: r_ready = rd_rdy_i; b_ready = wr_rdy_i. R/B fields map combinationally to rd_*_o / wr_*_o.

## Timing
- All handshakes are combinational from the inputs, so zero-cycle grant is possible. Minimum write occupancy is blen+1 cycles.
- Once asserted, a valid is never withdrawn before its handshake. While a request is pending the outstanding counter can only fall, so the gating condition cannot turn false mid-request.
- Reset (asynchronous, any time, including mid-burst): FSM to IDLE, aw_done_q = 0, beat_q = 0, rd_ot_q = 0, wr_ot_q = 0. With no requests present, all valid and grant outputs are 0.
- Back-to-back writes: a new request may start in the cycle after wr_gnt_o.

## Test plan
- Single-beat write, aw_ready = w_ready = 1 at request → wr_gnt_o in the same cycle, w.last = 1, wr_ot_q goes 0→1.
- 4-beat write with aw_ready held low for 6 cycles and w_ready always 1 → beats 0..3 sent in cycles 0..3, w_valid low from cycle 4. gnt arrives in the cycle aw_ready rises; no beat is repeated.
- 4-beat write with w_ready toggling 1010… and aw_ready in cycle 2 → data order wr_data_i[0..3], w.last only on beat 3, gnt on the 4th W handshake.
- MaxOutstanding = 2: issue 3 reads with no R responses → third read keeps ar_valid = 0 and no gnt. An R-last on ID 0 is followed the next cycle by ar_valid = 1 for the third read.
- B handshake and new wr_gnt_o in the same cycle with wr_ot_q = 2 → wr_ot_q stays 2.
- Assert rst_ni low during beat 2 of a 4-beat write → after release: IDLE, beat_q = 0, wr_ot_q = 0, no stale w_valid.
